imul_sequencer: RTL and testbench

Multi-cycle shift-add multiply controller that implements the `IMUL` opcode of the mini ALU without a combinational multiplier array. It sits beside the ALU execute stage: decode raises a start request with the two source operands, and the block stalls instruction fetch while it iterates. It then presents a 2×WIDTH-bit result with a one-cycle write strobe into the 32-bit data RAM.

---
 rtl/imul_sequencer.sv | 118 +++++++++++
 tb/tb_imul_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/imul_sequencer.sv
// imul_sequencer: multi-cycle shift-add multiplier controller for the IMUL opcode.
// Latches two WIDTH-bit operands on a start request, iterates one partial
// product per cycle, and presents a 2*WIDTH-bit product with a one-cycle
// write strobe for the 32-bit data RAM.
// Optional build macro: IMUL_EARLY_EXIT_EN -- finish as soon as the remaining
// multiplier bits are all zero (variable latency, identical results).
module imul_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 iStart,
   input  logic                 iSigned,
   input  logic [WIDTH-1:0]     iA,
   input  logic [WIDTH-1:0]     iB,
   output logic                 oBusy,
   output logic                 oStall,
   output logic                 oDone,
   output logic                 oWriteEnable32,
   output logic [2*WIDTH-1:0]   oResult
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]      LAST_ITER = CW'(WIDTH - 1);
   localparam logic [CW-1:0]      ONE_CNT   = CW'(1);
   localparam logic [WIDTH-1:0]   ONE_W     = WIDTH'(1);
   localparam logic [2*WIDTH-1:0] ONE_2W    = (2*WIDTH)'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               stateReg;
   logic [2*WIDTH-1:0]   mcandReg;
   logic [2*WIDTH-1:0]   accReg;
   logic [2*WIDTH-1:0]   resultReg;
   logic [WIDTH-1:0]     mplierReg;
   logic [CW-1:0]        countReg;
   logic                 negReg;

   logic [WIDTH-1:0]     magA;
   logic [WIDTH-1:0]     magB;
   logic [2*WIDTH-1:0]   accSum;
   logic [2*WIDTH-1:0]   finalProd;
   logic [WIDTH-1:0]     mplierShift;
   logic                 lastIter;

   // Operand magnitudes; the most negative value maps onto 2^(WIDTH-1), which
   // still fits in WIDTH unsigned bits, so no extra bit is needed.
   assign magA = (iSigned && iA[WIDTH-1]) ? (~iA + ONE_W) : iA;
   assign magB = (iSigned && iB[WIDTH-1]) ? (~iB + ONE_W) : iB;

   // One partial product per cycle, and the sign-corrected product of the
   // final iteration so the result register loads on the DONE entry edge.
   assign accSum      = accReg + (mplierReg[0] ? mcandReg : '0);
   assign mplierShift = mplierReg >> 1;
   assign finalProd   = negReg ? (~accSum + ONE_2W) : accSum;

`ifdef IMUL_EARLY_EXIT_EN
   // Stop once no set multiplier bits remain after this cycle's shift.
   assign lastIter = (countReg == LAST_ITER) || (mplierShift == '0);
`else
   assign lastIter = (countReg == LAST_ITER);
`endif

   // Control FSM plus datapath registers; reset wins over a same-edge start.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         stateReg  <= IDLE;
         mcandReg  <= '0;
         mplierReg <= '0;
         accReg    <= '0;
         countReg  <= '0;
         negReg    <= 1'b0;
         resultReg <= '0;
      end else begin
         case (stateReg)
            IDLE: begin
               if (iStart) begin
                  mcandReg  <= {{WIDTH{1'b0}}, magA};
                  mplierReg <= magB;
                  accReg    <= '0;
                  negReg    <= iSigned & (iA[WIDTH-1] ^ iB[WIDTH-1]);
                  countReg  <= '0;
                  stateReg  <= RUN;
               end
            end
            RUN: begin
               accReg    <= accSum;
               mcandReg  <= mcandReg << 1;
               mplierReg <= mplierShift;
               countReg  <= countReg + ONE_CNT;
               if (lastIter) begin
                  resultReg <= finalProd;
                  stateReg  <= DONE;
               end
            end
            DONE: begin
               stateReg <= IDLE;
            end
            default: begin
               stateReg <= IDLE;
            end
         endcase
      end
   end

   // Flags decode straight from the state register; only the stall request
   // looks at iStart so fetch freezes in the very cycle the request appears.
   assign oBusy          = (stateReg != IDLE);
   assign oDone          = (stateReg == DONE);
   assign oWriteEnable32 = (stateReg == DONE);
   assign oStall         = ((stateReg == IDLE) && iStart) || (stateReg == RUN);
   assign oResult        = resultReg;

endmodule

// File: tb/tb_imul_sequencer.sv
// tb_imul_sequencer: vector table, hand-written corner sequences and random
// operands checked against an arithmetic reference product and latency rule.
module tb_imul_sequencer;

   localparam int W = 16;

   logic            Clock = 1'b0;
   logic            Reset;
   logic            iStart;
   logic            iSigned;
   logic [W-1:0]    iA;
   logic [W-1:0]    iB;
   logic            oBusy;
   logic            oStall;
   logic            oDone;
   logic            oWriteEnable32;
   logic [2*W-1:0]  oResult;

   int total = 0;
   int bad   = 0;

   imul_sequencer #(.WIDTH(W)) dut (
      .Clock          (Clock),
      .Reset          (Reset),
      .iStart         (iStart),
      .iSigned        (iSigned),
      .iA             (iA),
      .iB             (iB),
      .oBusy          (oBusy),
      .oStall         (oStall),
      .oDone          (oDone),
      .oWriteEnable32 (oWriteEnable32),
      .oResult        (oResult)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic           s;
      logic [2*W-1:0] want;
   } vec_t;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
      end
   endtask

   // Reference product: interpret operands as integers and multiply.
   function automatic logic [2*W-1:0] refProd(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      longint va;
      longint vb;
      longint p;
      va = longint'(a);
      vb = longint'(b);
      if (s && a[W-1]) va = va - (longint'(1) << W);
      if (s && b[W-1]) vb = vb - (longint'(1) << W);
      p = va * vb;
      return p[2*W-1:0];
   endfunction

   // Reference latency (start cycle -> DONE cycle).
   function automatic int expLat(input logic [W-1:0] b, input logic s);
`ifdef IMUL_EARLY_EXIT_EN
      int mag;
      int n;
      mag = int'(b);
      if (s && b[W-1]) mag = (1 << W) - mag;
      n = $clog2(mag + 1);
      if (n < 1) n = 1;
      return n + 1;
`else
      return W + 1;
`endif
   endfunction

   // One IMUL: start, optional re-start requests during cycles rsFrom..rsTo,
   // wait (bounded) for DONE, check timing, result and the single strobe.
   task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int rsFrom, input int rsTo, input string tag);
      logic [2*W-1:0] want;
      int lat;
      int cyc;
      logic stallOk;
      want = refProd(a, b, s);
      lat  = expLat(b, s);
      @(negedge Clock);
      iA = a; iB = b; iSigned = s; iStart = 1'b1;
      #1;
      check({tag, ":stall_start"}, 64'(oStall), 64'd1);
      check({tag, ":busy_start"}, 64'(oBusy), 64'd0);
      @(negedge Clock);
      iStart = 1'b0;
      iA = W'($urandom); iB = W'($urandom); iSigned = 1'($urandom);
      cyc = 1;
      stallOk = 1'b1;
      iStart = (cyc >= rsFrom && cyc <= rsTo);
      #1;
      while (!oDone && cyc < 40) begin
         if (!(oStall && oBusy)) stallOk = 1'b0;
         @(negedge Clock);
         cyc++;
         iStart = (cyc >= rsFrom && cyc <= rsTo);
         if (iStart) begin
            iA = W'($urandom); iB = W'($urandom);
         end
         #1;
      end
      check({tag, ":latency"}, 64'(cyc), 64'(lat));
      check({tag, ":result"}, 64'(oResult), 64'(want));
      check({tag, ":we_in_done"}, 64'(oWriteEnable32), 64'd1);
      check({tag, ":stall_in_done"}, 64'(oStall), 64'd0);
      check({tag, ":stall_busy_run"}, 64'(stallOk), 64'd1);
      iStart = 1'b0;
      @(negedge Clock);
      #1;
      check({tag, ":done_pulse_one"}, 64'(oDone | oWriteEnable32), 64'd0);
      check({tag, ":busy_after"}, 64'(oBusy), 64'd0);
      check({tag, ":result_hold"}, 64'(oResult), 64'(want));
      $display("op %s a=0x%04h b=0x%04h s=%0d result=0x%08h want=0x%08h lat=%0d",
               tag, a, b, s, oResult, want, cyc);
   endtask

   task automatic quietCycles(input int n, input string tag);
      int seen;
      seen = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge Clock);
         #1;
         if (oDone || oWriteEnable32) seen++;
      end
      check({tag, ":no_done"}, 64'(seen), 64'd0);
   endtask

   vec_t vecs[10];

   initial begin
      vecs[0] = '{16'h0003, 16'h0005, 1'b0, 32'h0000000F};
      vecs[1] = '{16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1};
      vecs[2] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000};
      vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
      vecs[4] = '{16'h0007, 16'h0001, 1'b0, 32'h00000007};
      vecs[5] = '{16'h0007, 16'h8000, 1'b0, 32'h00038000};
      vecs[6] = '{16'h0000, 16'h1234, 1'b0, 32'h00000000};
      vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001};
      vecs[8] = '{16'h8000, 16'h0001, 1'b1, 32'hFFFF8000};
      vecs[9] = '{16'h7FFF, 16'h8000, 1'b1, 32'hC0008000};

      Reset = 1'b1; iStart = 1'b0; iSigned = 1'b0; iA = '0; iB = '0;
      repeat (3) @(negedge Clock);
      Reset = 1'b0;
      #1;
      check("reset:busy", 64'(oBusy), 64'd0);
      check("reset:done", 64'(oDone), 64'd0);
      check("reset:we", 64'(oWriteEnable32), 64'd0);
      check("reset:stall", 64'(oStall), 64'd0);
      check("reset:result", 64'(oResult), 64'd0);

      // Table vectors; the literal expectations also cross-check the model.
      for (int i = 0; i < 10; i++) begin
         check($sformatf("vec%0d:model", i), 64'(refProd(vecs[i].a, vecs[i].b, vecs[i].s)), 64'(vecs[i].want));
         runOp(vecs[i].a, vecs[i].b, vecs[i].s, 0, -1, $sformatf("vec%0d", i));
      end

      // Start requests during RUN cycles 3..10 are ignored.
      runOp(16'h0003, 16'h0005, 1'b0, 3, 10, "restart_ignored");
      quietCycles(20, "restart_ignored");

      // Reset in RUN cycle 5 aborts the operation.
      @(negedge Clock);
      iA = 16'h1234; iB = 16'h5678; iSigned = 1'b0; iStart = 1'b1;
      @(negedge Clock);
      iStart = 1'b0;
      repeat (4) @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      #1;
      check("abort:busy", 64'(oBusy), 64'd0);
      check("abort:result", 64'(oResult), 64'd0);
      check("abort:done", 64'(oDone), 64'd0);
      $display("op abort busy=%0d result=0x%08h", oBusy, oResult);
      quietCycles(20, "abort");
      runOp(16'h0002, 16'h0002, 1'b0, 0, -1, "after_abort");

      // Reset and start on the same edge: reset wins.
      @(negedge Clock);
      Reset = 1'b1; iStart = 1'b1; iA = 16'h0009; iB = 16'h0009;
      @(negedge Clock);
      Reset = 1'b0; iStart = 1'b0;
      #1;
      check("reset_vs_start:busy", 64'(oBusy), 64'd0);
      $display("op reset_vs_start busy=%0d", oBusy);

      // Random operands, occasionally with small multipliers.
      for (int i = 0; i < 30; i++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         logic rs;
         ra = W'($urandom);
         rb = (i % 4 == 0) ? W'($urandom_range(0, 7)) : W'($urandom);
         rs = 1'($urandom);
         runOp(ra, rb, rs, 0, -1, $sformatf("rand%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
